// File: rtl/spi_slave_pkg.sv
// Shared types and default widths for the SPI slave protocol controller.
package spi_slave_pkg;

  // Protocol states; encoding is fixed so debug captures decode consistently.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4,
    TX_WAIT   = 3'd5,
    TX_SHIFT  = 3'd6,
    DONE      = 3'd7
  } state_e;

  localparam int RX_WIDTH_DEF = 10;
  localparam int TX_WIDTH_DEF = 8;

endpackage

// File: rtl/spi_tx_serializer.sv
// MSB-first parallel-to-serial shifter for read data returned to the master.
module spi_tx_serializer #(
  parameter int TX_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [TX_WIDTH-1:0] load_data,
  input  logic                active,
  output logic                last,
  output logic                serial_out
);

  localparam int CW = (TX_WIDTH > 1) ? $clog2(TX_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(TX_WIDTH - 1);

  logic [TX_WIDTH-1:0] tx_shreg_reg;
  logic [CW-1:0]       tx_cnt_reg;

  // Load a fresh byte, otherwise shift one bit out per cycle while active.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_shreg_reg <= '0;
      tx_cnt_reg   <= '0;
    end else if (load) begin
      tx_shreg_reg <= load_data;
      tx_cnt_reg   <= '0;
    end else if (active) begin
      tx_shreg_reg <= {tx_shreg_reg[TX_WIDTH-2:0], 1'b0};
      tx_cnt_reg   <= tx_cnt_reg + 1'b1;
    end
  end

  // Flag the final bit and gate the line low whenever not shifting.
  always_comb begin
    last       = (tx_cnt_reg == LAST_IDX);
    serial_out = active & tx_shreg_reg[TX_WIDTH-1];
  end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave protocol FSM: frames 10-bit command words from MOSI using the
// external bit counter and returns 8-bit read data on MISO.
module spi_slave_ctrl
  import spi_slave_pkg::*;
#(
  parameter int RX_WIDTH = RX_WIDTH_DEF,
  parameter int TX_WIDTH = TX_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SS_n,
  input  logic                MOSI,
  output logic                MISO,
  output logic                cnt_start,
  input  logic                cnt_finish,
  output logic [RX_WIDTH-1:0] rx_data,
  output logic                rx_valid,
  input  logic [TX_WIDTH-1:0] tx_data,
  input  logic                tx_valid
);

  state_e              state_reg, state_next;
  logic                rd_addr_seen_reg, rd_addr_seen_next;
  logic [RX_WIDTH-1:0] rx_shreg_reg;
  logic [RX_WIDTH-1:0] rx_data_reg;
  logic                rx_valid_reg;
  logic                rx_state;
  logic                rx_capture;
  logic                tx_load;
  logic                tx_active;
  logic                tx_last;

  // Next-state and control decode; a deselect overrides every other event.
  always_comb begin
    state_next        = state_reg;
    rd_addr_seen_next = rd_addr_seen_reg;
    rx_state          = 1'b0;
    cnt_start         = 1'b0;
    rx_capture        = 1'b0;
    tx_load           = 1'b0;
    tx_active         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!SS_n) state_next = CHK_CMD;
      end
      CHK_CMD: begin
        if (!MOSI)                 state_next = WRITE;
        else if (rd_addr_seen_reg) state_next = READ_DATA;
        else                       state_next = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        rx_state  = 1'b1;
        cnt_start = 1'b1;
        if (cnt_finish) begin
          rx_capture = 1'b1;
          if (state_reg == READ_DATA) begin
            state_next = TX_WAIT;
          end else begin
            state_next = DONE;
          end
          if (state_reg == READ_ADD) rd_addr_seen_next = 1'b1;
        end
      end
      TX_WAIT: begin
        if (tx_valid) begin
          tx_load    = 1'b1;
          state_next = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        tx_active = 1'b1;
        if (tx_last) begin
          state_next        = DONE;
          rd_addr_seen_next = 1'b0;
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (SS_n && (state_reg != IDLE)) begin
      state_next        = IDLE;
      rd_addr_seen_next = rd_addr_seen_reg;
      rx_capture        = 1'b0;
      tx_load           = 1'b0;
    end
  end

  // State and read-address tracking registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      rd_addr_seen_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      rd_addr_seen_reg <= rd_addr_seen_next;
    end
  end

  // Deserialise MOSI MSB first until the counter reports a full word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_shreg_reg <= '0;
    end else if (rx_state && !cnt_finish) begin
      rx_shreg_reg <= {rx_shreg_reg[RX_WIDTH-2:0], MOSI};
    end
  end

  // Publish a completed word with a single-cycle strobe; hold it until the next one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
    end else begin
      rx_valid_reg <= rx_capture;
      if (rx_capture) rx_data_reg <= rx_shreg_reg;
    end
  end

  spi_tx_serializer #(
    .TX_WIDTH (TX_WIDTH)
  ) u_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tx_load),
    .load_data  (tx_data),
    .active     (tx_active),
    .last       (tx_last),
    .serial_out (MISO)
  );

  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Self-checking bench for spi_slave_ctrl: transaction-level reference model
// plus a behavioural model of the external 10-bit bit counter.
module tb_spi_slave_ctrl;

  localparam int RXW = 10;
  localparam int TXW = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           SS_n;
  logic           MOSI;
  logic           MISO;
  logic           cnt_start;
  logic           cnt_finish;
  logic [RXW-1:0] rx_data;
  logic           rx_valid;
  logic [TXW-1:0] tx_data;
  logic           tx_valid;

  int checks = 0;
  int errors = 0;
  int txn_id = 0;

  // Reference model state: whether a read address is pending and the last word delivered.
  bit             seen_m;
  logic [RXW-1:0] last_rx_m;

  always #5 clk = ~clk;

  spi_slave_ctrl #(.RX_WIDTH(RXW), .TX_WIDTH(TXW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .SS_n       (SS_n),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .cnt_start  (cnt_start),
    .cnt_finish (cnt_finish),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid)
  );

  // External bit counter: counts while started, clears when not, finishes at RXW.
  logic [3:0] bit_cnt;
  always @(posedge clk) begin
    if (!rst_n || !cnt_start) bit_cnt <= 4'd0;
    else if (bit_cnt != 4'(RXW)) bit_cnt <= bit_cnt + 4'd1;
  end
  assign cnt_finish = (bit_cnt == 4'(RXW));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (txn %0d, t=%0t)", tag, got, exp, txn_id, $time);
    end
  endtask

  task automatic expect_quiet(input string tag);
    check_val({tag, "_miso"}, 32'(MISO), 32'd0);
    check_val({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check_val({tag, "_cnt_start"}, 32'(cnt_start), 32'd0);
  endtask

  // One SPI frame: command bit, 10 data bits, optional read-data return.
  // rx_abort >= 0 ends the frame (deselect or reset) after that many data bits;
  // tx_abort >= 0 deselects after that many MISO bits have been shown.
  task automatic run_txn(input bit cmd, input logic [RXW-1:0] word, input int rx_abort,
                         input bit abort_rst, input int tx_wait, input int tx_abort,
                         input logic [TXW-1:0] tx_byte);
    bit to_tx;
    to_tx = cmd && seen_m;
    txn_id++;
    $display("txn %0d: cmd=%0b word=%03h seen=%0b rx_abort=%0d rst=%0b tx_wait=%0d tx_abort=%0d byte=%02h",
             txn_id, cmd, word, seen_m, rx_abort, abort_rst, tx_wait, tx_abort, tx_byte);
    SS_n = 1'b0;
    MOSI = 1'($urandom);
    tick();
    expect_quiet("chk_cmd");
    MOSI = cmd;
    tick();
    for (int t = 1; t <= RXW + 1; t++) begin
      check_val("cnt_start_rx", 32'(cnt_start), 32'd1);
      check_val("rx_valid_early", 32'(rx_valid), 32'd0);
      check_val("miso_rx", 32'(MISO), 32'd0);
      if (rx_abort >= 0 && t == rx_abort + 1) begin
        SS_n = 1'b1;
        if (abort_rst) rst_n = 1'b0;
        tx_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        if (abort_rst) begin
          seen_m    = 1'b0;
          last_rx_m = '0;
        end
        expect_quiet("rx_abort");
        check_val("rx_data_abort", 32'(rx_data), 32'(last_rx_m));
        return;
      end
      MOSI     = (t <= RXW) ? word[RXW - t] : 1'($urandom);
      tx_valid = 1'($urandom);
      tx_data  = TXW'($urandom);
      tick();
    end
    tx_valid = 1'b0;
    check_val("rx_valid", 32'(rx_valid), 32'd1);
    check_val("rx_data", 32'(rx_data), 32'(word));
    check_val("cnt_start_end", 32'(cnt_start), 32'd0);
    check_val("miso_end", 32'(MISO), 32'd0);
    last_rx_m = word;
    if (cmd && !seen_m) seen_m = 1'b1;
    if (to_tx) begin
      for (int w = 0; w < tx_wait; w++) begin
        tick();
        check_val("miso_wait", 32'(MISO), 32'd0);
        check_val("rx_valid_wait", 32'(rx_valid), 32'd0);
      end
      tx_valid = 1'b1;
      tx_data  = tx_byte;
      if (tx_abort == 0) SS_n = 1'b1;
      tick();
      tx_valid = 1'b0;
      tx_data  = TXW'($urandom);
      if (tx_abort == 0) begin
        expect_quiet("tx_abort0");
        return;
      end
      for (int b = 0; b < TXW; b++) begin
        check_val("miso_bit", 32'(MISO), 32'(tx_byte[TXW-1-b]));
        check_val("rx_valid_tx", 32'(rx_valid), 32'd0);
        if (tx_abort == b + 1) begin
          SS_n = 1'b1;
          tick();
          expect_quiet("tx_abort");
          return;
        end
        tick();
      end
      seen_m = 1'b0;
    end else begin
      tick();
    end
    for (int d = 0; d < 3; d++) begin
      expect_quiet("done");
      MOSI     = 1'($urandom);
      tx_valid = 1'($urandom);
      tx_data  = TXW'($urandom);
      tick();
    end
    SS_n     = 1'b1;
    tx_valid = 1'b0;
    tick();
    expect_quiet("idle");
    check_val("rx_data_hold", 32'(rx_data), 32'(last_rx_m));
  endtask

  // Deselected gap between frames with stray tx_valid pulses that must be ignored.
  task automatic idle_gap();
    for (int i = 0; i < 2; i++) begin
      tx_valid = 1'($urandom);
      tx_data  = TXW'($urandom);
      tick();
      check_val("miso_idle", 32'(MISO), 32'd0);
    end
    tx_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    SS_n      = 1'b1;
    MOSI      = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    seen_m    = 1'b0;
    last_rx_m = '0;
    tick();
    tick();
    expect_quiet("reset");
    check_val("reset_rx_data", 32'(rx_data), 32'd0);
    rst_n = 1'b1;
    idle_gap();

    run_txn(1'b0, 10'h0A5, -1, 1'b0, 0, -1, 8'h00); idle_gap();
    run_txn(1'b1, 10'h207, -1, 1'b0, 0, -1, 8'h00); idle_gap();
    run_txn(1'b1, 10'h300, -1, 1'b0, 1, -1, 8'hC3); idle_gap();
    run_txn(1'b0, 10'h155,  5, 1'b0, 0, -1, 8'h00); idle_gap();
    run_txn(1'b1, 10'h011, -1, 1'b0, 0, -1, 8'h00); idle_gap();
    run_txn(1'b1, 10'h022, -1, 1'b0, 0,  3, 8'hA5); idle_gap();
    run_txn(1'b1, 10'h033, -1, 1'b0, 2, -1, 8'h5A); idle_gap();
    run_txn(1'b1, 10'h044, -1, 1'b0, 0, -1, 8'h00); idle_gap();
    run_txn(1'b1, 10'h3FF,  4, 1'b1, 0, -1, 8'h00); idle_gap();
    run_txn(1'b1, 10'h2AA, -1, 1'b0, 0, -1, 8'hFF); idle_gap();
    run_txn(1'b1, 10'h0F0, 10, 1'b0, 0, -1, 8'h00); idle_gap();
    run_txn(1'b1, 10'h0F1, -1, 1'b0, 0,  0, 8'h81); idle_gap();
    run_txn(1'b1, 10'h0F2, -1, 1'b0, 3,  8, 8'h7E); idle_gap();
    run_txn(1'b1, 10'h0F3, -1, 1'b0, 0, -1, 8'h96); idle_gap();

    for (int n = 0; n < 80; n++) begin
      bit             r_cmd;
      logic [RXW-1:0] r_word;
      int             r_rx_abort;
      bit             r_rst;
      int             r_tx_abort;
      r_cmd      = 1'($urandom);
      r_word     = RXW'($urandom);
      r_rx_abort = ($urandom_range(4) == 0) ? int'($urandom_range(10)) : -1;
      r_rst      = (r_rx_abort >= 0) && ($urandom_range(2) == 0);
      r_tx_abort = ($urandom_range(3) == 0) ? int'($urandom_range(8)) : -1;
      run_txn(r_cmd, r_word, r_rx_abort, r_rst, int'($urandom_range(3)), r_tx_abort, TXW'($urandom));
      idle_gap();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
